// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: builds the single pipeline Stall request from D-stage
// register hazards (Tuse/Tnew scheme) and from occupancy of the multi-cycle
// HI/LO multiply/divide unit. It also keeps a saturating count of stall cycles.
module hazard_stall_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       D_rs,
  input  logic [4:0]       D_rt,
  input  logic             D_use_rs,
  input  logic             D_use_rt,
  input  logic [1:0]       D_Tuse_rs,
  input  logic [1:0]       D_Tuse_rt,
  input  logic             D_is_md,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_Tnew,
  input  logic             E_md_start,
  input  logic [1:0]       E_md_op,
  output logic             Stall,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] MD_Cnt,
  output logic [31:0]      Stall_Cnt
);

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [31:0]      SCNT_MAX  = 32'hFFFF_FFFF;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             stall_rs_s, stall_rt_s, stall_md_s, stall_s;
  logic [CNT_W-1:0] load_val_s;

  // A D-stage operand must wait when an older producer still in E or M will
  // deliver its result later than the operand is needed. $zero never stalls.
  function automatic logic operand_hazard(
    input logic       use_op,
    input logic [4:0] ra,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (ra == e_wa) && (e_tnew > tuse);
    m_hit = (ra == m_wa) && (m_tnew > tuse);
    return use_op && (ra != 5'd0) && (e_hit || m_hit);
  endfunction

  // Combinational stall request, forced low while reset is held.
  always_comb begin
    stall_rs_s = operand_hazard(D_use_rs, D_rs, D_Tuse_rs, E_wa, E_Tnew, M_wa, M_Tnew);
    stall_rt_s = operand_hazard(D_use_rt, D_rt, D_Tuse_rt, E_wa, E_Tnew, M_wa, M_Tnew);
    stall_md_s = D_is_md && (E_md_start || (state_q == MD_BUSY));
    stall_s    = reset && (stall_rs_s || stall_rt_s || stall_md_s);
  end

  // MD scheduler next state: load on start (also restarts a busy unit),
  // count down while busy, return to idle after the last busy cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_val_s = E_md_op[1] ? DIV_LOAD : MULT_LOAD;
    case (state_q)
      MD_IDLE: begin
        if (E_md_start) begin
          state_d = MD_BUSY;
          cnt_d   = load_val_s;
        end else begin
          state_d = MD_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      MD_BUSY: begin
        if (E_md_start) begin
          state_d = MD_BUSY;
          cnt_d   = load_val_s;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = MD_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = MD_BUSY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != SCNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous active-low reset; an in-flight MD
  // operation is simply dropped when reset arrives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= MD_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall     = stall_s;
  assign MD_Busy   = (state_q == MD_BUSY);
  assign MD_Cnt    = cnt_q;
  assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: stimulus pushes per-cycle
// expectations tagged with a cycle number; a monitor compares them on the
// falling edge of that cycle.
module tb_hazard_stall_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_wa, M_wa;
  logic        D_use_rs, D_use_rt, D_is_md, E_md_start;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew, E_md_op;
  logic        Stall, MD_Busy;
  logic [3:0]  MD_Cnt;
  logic [31:0] Stall_Cnt;

  typedef struct {
    int          cyc;
    string       name;
    logic        stall;
    logic [31:0] scnt;
    logic        chk_md;
    logic        busy;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc;
  int          checks;
  int          errors;
  logic        exp_stall_cur;
  logic [31:0] exp_scnt;

  hazard_stall_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_is_md(D_is_md),
    .E_wa(E_wa), .E_Tnew(E_Tnew), .M_wa(M_wa), .M_Tnew(M_Tnew),
    .E_md_start(E_md_start), .E_md_op(E_md_op),
    .Stall(Stall), .MD_Busy(MD_Busy), .MD_Cnt(MD_Cnt), .Stall_Cnt(Stall_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle index, advanced on each rising edge
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clr();
    D_rs = 5'd0; D_rt = 5'd0; D_use_rs = 1'b0; D_use_rt = 1'b0;
    D_Tuse_rs = 2'd0; D_Tuse_rt = 2'd0; D_is_md = 1'b0;
    E_wa = 5'd0; E_Tnew = 2'd0; M_wa = 5'd0; M_Tnew = 2'd0;
    E_md_start = 1'b0; E_md_op = 2'd0;
  endtask

  task automatic load_use(input logic on);
    D_use_rs = on; D_rs = 5'd8; E_wa = 5'd8; E_Tnew = 2'd2; D_Tuse_rs = 2'd1;
  endtask

  // advance to just after the next rising edge, updating the counter model
  task automatic tick();
    logic rst_at_edge;
    logic st;
    rst_at_edge = reset;
    st = exp_stall_cur;
    @(posedge clk);
    #1;
    if (!rst_at_edge) exp_scnt = 32'd0;
    else if (st && (exp_scnt != 32'hFFFF_FFFF)) exp_scnt = exp_scnt + 32'd1;
    exp_stall_cur = 1'b0;
  endtask

  task automatic sb_push(input string nm, input logic st, input logic chk_md,
                         input logic busy, input logic [3:0] cnt);
    exp_t e;
    exp_stall_cur = st;
    e.cyc = cyc; e.name = nm; e.stall = st; e.scnt = exp_scnt;
    e.chk_md = chk_md; e.busy = busy; e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  // monitor: compare every expectation due in the current cycle
  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
        end else begin
          if (Stall !== e.stall) begin
            errors++;
            $display("FAIL %s cyc=%0d Stall: got %0b, expected %0b", e.name, cyc, Stall, e.stall);
          end
          checks++;
          if (Stall_Cnt !== e.scnt) begin
            errors++;
            $display("FAIL %s cyc=%0d Stall_Cnt: got %h, expected %h", e.name, cyc, Stall_Cnt, e.scnt);
          end
          if (e.chk_md) begin
            checks++;
            if (MD_Busy !== e.busy) begin
              errors++;
              $display("FAIL %s cyc=%0d MD_Busy: got %0b, expected %0b", e.name, cyc, MD_Busy, e.busy);
            end
            checks++;
            if (MD_Cnt !== e.cnt) begin
              errors++;
              $display("FAIL %s cyc=%0d MD_Cnt: got %0d, expected %0d", e.name, cyc, MD_Cnt, e.cnt);
            end
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    exp_stall_cur = 1'b0;
    exp_scnt = 32'd0;
    clr();
    reset = 1'b0;

    // reset state, and hazard masked while reset is low
    tick(); sb_push("rst_state", 1'b0, 1'b1, 1'b0, 4'd0);
    tick(); load_use(1'b1); sb_push("rst_masks_hazard", 1'b0, 1'b1, 1'b0, 4'd0);

    // seven load-use stalls straight out of reset
    tick(); reset = 1'b1; sb_push("load_use", 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      tick(); sb_push("load_use", 1'b1, 1'b0, 1'b0, 4'd0);
    end
    tick(); clr(); sb_push("stall_cnt_7", 1'b0, 1'b1, 1'b0, 4'd0);

    // load-use variants that must not stall
    tick(); load_use(1'b1); E_Tnew = 2'd1; sb_push("e_tnew_1", 1'b0, 1'b0, 1'b0, 4'd0);
    tick(); load_use(1'b1); D_rs = 5'd0; E_wa = 5'd0; sb_push("rs_zero", 1'b0, 1'b0, 1'b0, 4'd0);
    tick(); load_use(1'b1); D_use_rs = 1'b0; sb_push("rs_unused", 1'b0, 1'b0, 1'b0, 4'd0);

    // M-stage producer on the rt path
    tick(); clr(); M_wa = 5'd5; M_Tnew = 2'd1; D_rt = 5'd5; D_use_rt = 1'b1; D_Tuse_rt = 2'd0;
    sb_push("m_rt_hazard", 1'b1, 1'b0, 1'b0, 4'd0);
    tick(); D_Tuse_rt = 2'd1; sb_push("m_rt_tuse_1", 1'b0, 1'b0, 1'b0, 4'd0);

    // mult followed by a waiting mflo; data hazard overlaps in one cycle
    tick(); clr(); D_is_md = 1'b1; E_md_start = 1'b1; E_md_op = 2'b00;
    sb_push("mult_start", 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick(); E_md_start = 1'b0;
      load_use(i == 1);
      sb_push("mult_busy", 1'b1, 1'b1, 1'b1, 4'(5 - i));
    end
    tick(); load_use(1'b0); sb_push("mult_done", 1'b0, 1'b1, 1'b0, 4'd0);

    // divu without MD-dependent instruction in D
    tick(); clr(); E_md_start = 1'b1; E_md_op = 2'b11;
    sb_push("divu_start", 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      tick(); E_md_start = 1'b0; sb_push("divu_busy", 1'b0, 1'b1, 1'b1, 4'(10 - i));
    end
    tick(); sb_push("divu_done", 1'b0, 1'b1, 1'b0, 4'd0);

    // a new start while busy reloads the count from the new op
    tick(); E_md_start = 1'b1; E_md_op = 2'b01; sb_push("reload_mult", 1'b0, 1'b1, 1'b0, 4'd0);
    tick(); E_md_start = 1'b0; sb_push("reload_busy", 1'b0, 1'b1, 1'b1, 4'd5);
    tick(); E_md_start = 1'b1; E_md_op = 2'b10; sb_push("reload_div", 1'b0, 1'b1, 1'b1, 4'd4);
    for (int i = 0; i < 10; i++) begin
      tick(); E_md_start = 1'b0; sb_push("reload_count", 1'b0, 1'b1, 1'b1, 4'(10 - i));
    end
    tick(); sb_push("reload_done", 1'b0, 1'b1, 1'b0, 4'd0);

    // reset in the 4th busy cycle of a divide
    tick(); E_md_start = 1'b1; E_md_op = 2'b10; sb_push("div_start", 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); E_md_start = 1'b0; sb_push("div_busy", 1'b0, 1'b1, 1'b1, 4'(10 - i));
    end
    tick(); reset = 1'b0; D_is_md = 1'b1; load_use(1'b1);
    sb_push("rst_mid_div", 1'b0, 1'b1, 1'b1, 4'd7);
    tick(); sb_push("after_rst", 1'b0, 1'b1, 1'b0, 4'd0);
    tick(); reset = 1'b1; clr(); sb_push("rst_released", 1'b0, 1'b1, 1'b0, 4'd0);

    // saturation from a preset counter
    tick(); force dut.stall_cnt_q = 32'hFFFF_FFFE; exp_scnt = 32'hFFFF_FFFE;
    sb_push("preset", 1'b0, 1'b0, 1'b0, 4'd0);
    tick(); release dut.stall_cnt_q; load_use(1'b1);
    sb_push("sat_1", 1'b1, 1'b0, 1'b0, 4'd0);
    tick(); sb_push("sat_2", 1'b1, 1'b0, 1'b0, 4'd0);
    tick(); sb_push("sat_3", 1'b1, 1'b0, 1'b0, 4'd0);
    tick(); clr(); sb_push("sat_hold", 1'b0, 1'b1, 1'b0, 4'd0);

    tick();
    tick();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
